adc_mch_reader: RTL and testbench
=================================

# adc_mch_reader

Multi-channel serial ADC frame reader, the parametrised successor of the single-channel 24-bit reader inside `adc045_wrap`. It waits for DRDY and clocks `CH_NUM` samples of `SAMPLE_W` bits out of the converter over a 3-wire serial port (`sclk`/`dout`/`din`). It streams each sample upward with its channel index and shifts register-write words out on `din` between frames. It sits between the ADC pins and the acquisition/DSP layer and drives the converter's `start` pin.

## Interface
- `CH_NUM`, 4: channels per frame, 1..16.
- `SAMPLE_W`, 24: bits per sample, 8..32, MSB first, two's complement.
- `SCLK_DIV`, 4: `sclk` half-period in `adc_clk` cycles, ≥2.
- `WREG_W`, 16: register-write word width.
- `adc_clk  in  1`: clock, all logic on its rising edge.
- `nRST  in  1`: reset, asynchronous, active-low; clock is `adc_clk`.
- `drdy  in  1`: converter data-ready, active high, asynchronous (2-flop sync inside).
- `dout  in  1`: serial data from converter.
- `sclk  out  1`: serial clock, idles low.
- `din  out  1`: serial data to converter.
- `cs_n  out  1`: chip select, active low.
- `start  out  1`: converter START pin, level.
- `start_req  in  1`: pulse, sets work mode.
- `stop_req  in  1`: pulse, clears work mode.
- `wreg_req  in  1`: pulse, send `wreg_word`.
- `wreg_word  in  WREG_W`: captured on the `wreg_req` cycle.
- `busy  out  1`: state ≠ IDLE.
- `smp_valid  out  1`: one-cycle pulse, sample available.
- `smp_ch  out  $clog2(CH_NUM)` (min 1): channel of the current sample.
- `smp_data  out  SAMPLE_W`: sample value.
- `frame_done  out  1`: pulse, coincident with the last channel's `smp_valid`.
- `overrun  out  1`: pulse, DRDY rose during SHIFT.
- `crc_err  out  1`: pulse at frame end (see Configuration).

## Operation
- Reset values: `sclk`=0, `din`=0, `cs_n`=1, `start`=0, `busy`=0, `smp_valid`=0, `smp_ch`=0, `smp_data`=0, `frame_done`=0, `overrun`=0, `crc_err`=0. Work mode is cleared and the wreg pending flag is cleared.
- Work mode: `start_req` sets it and `stop_req` clears it. If both arrive in the same cycle, stop wins. The `start` output equals the work-mode flag.
- States:
  - IDLE: if wreg is pending, go to WREG. Otherwise, if a DRDY rising edge is seen in work mode, go to SHIFT. DRDY seen outside work mode is ignored.
  - SHIFT: clock `CH_NUM*SAMPLE_W` bits with `cs_n`=0. Then go to CRC (macro on) or DONE.
  - CRC: clock 8 more bits. Then go to DONE.
  - WREG: `cs_n`=0, shift `wreg_word` MSB first on `din` for `WREG_W` bits. Then go to DONE.
  - DONE: hold `cs_n`=1 for `SCLK_DIV` cycles. Then go to IDLE.
- Bit counter: a per-channel counter runs 0..SAMPLE_W-1 and a channel counter runs 0..CH_NUM-1. Both wrap to 0.
- `wreg_req` while busy is latched into a single pending flag and served in the next IDLE, so a pending write takes priority over DRDY. A second `wreg_req` while a write is already pending overwrites the pending word.
- A DRDY edge during SHIFT asserts `overrun` for one cycle. The current frame completes and that edge is discarded.
- `stop_req` mid-frame completes the frame; `start` drops immediately.
- `nRST` asserted mid-operation: all outputs return to reset values at once and any partial sample is discarded.

## Timing
- DRDY synchroniser plus edge detect: 3 cycles. `cs_n` falls the next cycle.
- First `sclk` rise occurs `SCLK_DIV` cycles after `cs_n` falls. `sclk` period is `2*SCLK_DIV` cycles.
- `dout` is sampled in the cycle `sclk` is driven high. `din` changes in the cycle `sclk` is driven low.
- `smp_valid` goes high in the cycle after the last bit of a channel is sampled. `smp_ch`/`smp_data` hold their values until the next `smp_valid`.
- Frame length in SHIFT: `CH_NUM*SAMPLE_W*2*SCLK_DIV` cycles.

## Configuration
- `ADC_MCH_READER_CRC_EN` defined:
  - CRC state is compiled in, with a CRC-8 (poly 0x07, init 0x00) over all sample bits.
  - The received byte is compared against the computed CRC.
  - On mismatch, `crc_err` pulses together with `frame_done`, and `frame_done` is delayed by the 8 CRC bits.
- Undefined: the CRC state and logic are absent and `crc_err` is tied to 0.

## Structure
- Package `adc_mch_pkg`:
  - state enum (IDLE, SHIFT, CRC, WREG, DONE)
  - `CRC8_POLY`
  - `CRC8_INIT`
  - function `crc8_step(crc, bit)`
- Sub-module `adc_sclk_gen`: divider that emits `sclk` plus one-cycle `rise`/`fall` strobes, enabled by the FSM.

## Test plan
- CH_NUM=4, SAMPLE_W=24, SCLK_DIV=2; `start_req`, DRDY, channels 0x7FFFFF/0x800000/0x000001/0xABCDEF → four `smp_valid` pulses with `smp_ch` 0..3 and exact data; `frame_done` coincides with ch3; 384 cycles of SHIFT.
- DRDY without `start_req` → `cs_n` stays 1 and no `smp_valid`.
- `wreg_req` with 0xA55A during SHIFT → frame completes, then WREG shifts 1010010101011010 on `din`, then `cs_n` returns to 1.
- Second DRDY edge mid-frame → one `overrun` pulse; frame data intact; no second frame.
- `nRST` low at bit 30 of a frame → all outputs at reset values; a following start/DRDY yields a clean frame.
- With `ADC_MCH_READER_CRC_EN`: correct CRC byte → `crc_err`=0; one flipped data bit → `crc_err` pulse with `frame_done`.

Source files
------------

// File: rtl/adc_mch_pkg.sv
// adc_mch_pkg: shared state encodings and CRC-8 helper for the multi-channel ADC reader.
// Rev 1.0
`default_nettype none

package adc_mch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SHIFT = 3'd1;
  localparam state_t ST_CRC   = 3'd2;
  localparam state_t ST_WREG  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial bit of a non-reflected CRC-8, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic data_bit);
    logic fb;
    fb = crc[7] ^ data_bit;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: serial clock divider with one-cycle rise/fall strobes; idles low when disabled.
// Rev 1.0
`default_nettype none

module adc_sclk_gen #(
  parameter int SCLK_DIV = 4
) (
  input  logic adc_clk,
  input  logic nRST,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(SCLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = en && (cnt == CNT_W'(SCLK_DIV - 1));
  // Strobes mark the cycle in which sclk is being driven to its new level.
  assign rise = tick & ~sclk;
  assign fall = tick & sclk;

  always_ff @(posedge adc_clk or negedge nRST) begin
    if (!nRST) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_mch_reader.sv
// adc_mch_reader: multi-channel serial ADC frame reader with register-write path.
// Optional CRC-8 frame check compiled in with `define ADC_MCH_READER_CRC_EN. Rev 1.0
`default_nettype none

module adc_mch_reader
  import adc_mch_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int SAMPLE_W = 24,
  parameter int SCLK_DIV = 4,
  parameter int WREG_W   = 16,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                adc_clk,
  input  logic                nRST,
  input  logic                drdy,
  input  logic                dout,
  output logic                sclk,
  output logic                din,
  output logic                cs_n,
  output logic                start,
  input  logic                start_req,
  input  logic                stop_req,
  input  logic                wreg_req,
  input  logic [WREG_W-1:0]   wreg_word,
  output logic                busy,
  output logic                smp_valid,
  output logic [CH_W-1:0]     smp_ch,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                frame_done,
  output logic                overrun,
  output logic                crc_err
);

  localparam int M1   = (SAMPLE_W > WREG_W) ? SAMPLE_W : WREG_W;
  localparam int M2   = (M1 > SCLK_DIV) ? M1 : SCLK_DIV;
  localparam int BW   = $clog2(M2);

  state_t              state;
  logic [2:0]          drdy_s;
  logic                drdy_edge;
  logic                work;
  logic                pend;
  logic [WREG_W-1:0]   pend_word;
  logic [WREG_W-1:0]   wsh;
  logic [SAMPLE_W-2:0] sh;
  logic [BW-1:0]       bit_cnt;
  logic [CH_W-1:0]     ch_cnt;
  logic                last;
  logic                sck_en;
  logic                sck_rise;
  logic                sck_fall;
`ifdef ADC_MCH_READER_CRC_EN
  logic [7:0]          crc_calc;
  logic [7:0]          crc_rx;
`endif

  assign drdy_edge = drdy_s[1] & ~drdy_s[2];
  assign busy      = (state != ST_IDLE);
  assign start     = work;
  assign sck_en    = (state == ST_SHIFT) || (state == ST_CRC) || (state == ST_WREG);

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .adc_clk (adc_clk),
    .nRST    (nRST),
    .en      (sck_en),
    .sclk    (sclk),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

`ifndef ADC_MCH_READER_CRC_EN
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge adc_clk or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      drdy_s     <= '0;
      work       <= 1'b0;
      pend       <= 1'b0;
      pend_word  <= '0;
      wsh        <= '0;
      sh         <= '0;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      last       <= 1'b0;
      din        <= 1'b0;
      cs_n       <= 1'b1;
      smp_valid  <= 1'b0;
      smp_ch     <= '0;
      smp_data   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef ADC_MCH_READER_CRC_EN
      crc_calc   <= CRC8_INIT;
      crc_rx     <= '0;
      crc_err    <= 1'b0;
`endif
    end else begin
      drdy_s     <= {drdy_s[1:0], drdy};
      smp_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= drdy_edge && (state == ST_SHIFT);
`ifdef ADC_MCH_READER_CRC_EN
      crc_err    <= 1'b0;
`endif
      work <= stop_req ? 1'b0 : (start_req ? 1'b1 : work);
      // A new request always wins over the clear that happens when IDLE serves the old one.
      pend <= wreg_req | (pend & (state != ST_IDLE));
      if (wreg_req) pend_word <= wreg_word;

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          last    <= 1'b0;
          if (pend) begin
            state <= ST_WREG;
            cs_n  <= 1'b0;
            din   <= pend_word[WREG_W-1];
            wsh   <= pend_word << 1;
          end else if (drdy_edge && work) begin
            state    <= ST_SHIFT;
            cs_n     <= 1'b0;
            ch_cnt   <= '0;
`ifdef ADC_MCH_READER_CRC_EN
            crc_calc <= CRC8_INIT;
`endif
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sh <= {sh[SAMPLE_W-3:0], dout};
`ifdef ADC_MCH_READER_CRC_EN
            crc_calc <= crc8_step(crc_calc, dout);
`endif
            if (bit_cnt == BW'(SAMPLE_W - 1)) begin
              bit_cnt   <= '0;
              smp_valid <= 1'b1;
              smp_data  <= {sh, dout};
              smp_ch    <= ch_cnt;
              if (ch_cnt == CH_W'(CH_NUM - 1)) begin
                ch_cnt <= '0;
                last   <= 1'b1;
`ifndef ADC_MCH_READER_CRC_EN
                frame_done <= 1'b1;
`endif
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          // Leave on the falling edge after the last bit so sclk ends low.
          if (sck_fall && last) begin
            last    <= 1'b0;
            bit_cnt <= '0;
`ifdef ADC_MCH_READER_CRC_EN
            state   <= ST_CRC;
`else
            state   <= ST_DONE;
            cs_n    <= 1'b1;
`endif
          end
        end
`ifdef ADC_MCH_READER_CRC_EN
        ST_CRC: begin
          if (sck_rise) begin
            crc_rx <= {crc_rx[6:0], dout};
            if (bit_cnt == BW'(7)) begin
              last       <= 1'b1;
              frame_done <= 1'b1;
              crc_err    <= ({crc_rx[6:0], dout} != crc_calc);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          if (sck_fall && last) begin
            state   <= ST_DONE;
            cs_n    <= 1'b1;
            bit_cnt <= '0;
            last    <= 1'b0;
          end
        end
`endif
        ST_WREG: begin
          if (sck_rise) begin
            if (bit_cnt == BW'(WREG_W - 1)) last <= 1'b1;
            else                             bit_cnt <= bit_cnt + 1'b1;
          end
          if (sck_fall) begin
            if (last) begin
              state   <= ST_DONE;
              cs_n    <= 1'b1;
              din     <= 1'b0;
              bit_cnt <= '0;
              last    <= 1'b0;
            end else begin
              din <= wsh[WREG_W-1];
              wsh <= wsh << 1;
            end
          end
        end
        ST_DONE: begin
          if (bit_cnt == BW'(SCLK_DIV - 1)) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_mch_reader.sv
// tb_adc_mch_reader: frame table plus scoreboard against a behavioural converter model.
`timescale 1ns/1ps
`default_nettype none

module tb_adc_mch_reader;

  localparam int CH_NUM   = 4;
  localparam int SAMPLE_W = 24;
  localparam int SCLK_DIV = 2;
  localparam int WREG_W   = 16;
  localparam int NBITS    = CH_NUM * SAMPLE_W;
`ifdef ADC_MCH_READER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int CS_LOW   = (NBITS + (CRC_ON ? 8 : 0)) * 2 * SCLK_DIV;
  localparam int WR_LOW   = WREG_W * 2 * SCLK_DIV;

  logic adc_clk = 1'b0;
  logic nRST, drdy, dout, sclk, din, cs_n, start;
  logic start_req, stop_req, wreg_req, busy, smp_valid;
  logic frame_done, overrun, crc_err;
  logic [WREG_W-1:0]   wreg_word;
  logic [1:0]          smp_ch;
  logic [SAMPLE_W-1:0] smp_data;

  adc_mch_reader #(.CH_NUM(CH_NUM), .SAMPLE_W(SAMPLE_W), .SCLK_DIV(SCLK_DIV), .WREG_W(WREG_W)) dut (
    .adc_clk(adc_clk), .nRST(nRST), .drdy(drdy), .dout(dout), .sclk(sclk), .din(din),
    .cs_n(cs_n), .start(start), .start_req(start_req), .stop_req(stop_req),
    .wreg_req(wreg_req), .wreg_word(wreg_word), .busy(busy), .smp_valid(smp_valid),
    .smp_ch(smp_ch), .smp_data(smp_data), .frame_done(frame_done), .overrun(overrun),
    .crc_err(crc_err)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct packed {
    logic [1:0]          ch;
    logic [SAMPLE_W-1:0] data;
    logic                last;
  } exp_t;

  typedef struct packed {
    logic [NBITS-1:0] samples;
    logic             corrupt;
    logic             exp_crc_err;
  } vec_t;

  exp_t exp_q[$];
  logic exp_crc_q[$];
  vec_t vecs[4];

  int n_vec = 0, n_bad = 0;
  int n_smp = 0, n_fd = 0, n_ovr = 0, n_rise = 0;
  logic [NBITS+7:0]  tx = '0;
  int                pos = 0;
  logic [WREG_W-1:0] rx_din = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] crc8_of(input logic [NBITS-1:0] s);
    logic [7:0] c;
    c = 8'h00;
    for (int i = NBITS - 1; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ s[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  // Converter: presents the next bit after each sclk rise, restarts at each cs_n fall.
  always @(negedge cs_n or posedge sclk) begin
    if (sclk) begin
      n_rise++;
      rx_din = {rx_din[WREG_W-2:0], din};
      if (!cs_n && pos > 0) begin
        pos--;
        dout = tx[pos];
      end
    end else begin
      pos  = NBITS + 7;
      dout = tx[pos];
    end
  end

  always @(negedge adc_clk) begin
    if (nRST) begin
      if (smp_valid) begin
        n_smp++;
        check("smp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("smp_ch", 64'(smp_ch), 64'(e.ch));
          check("smp_data", 64'(smp_data), 64'(e.data));
          check("frame_done_at_smp", 64'(frame_done), 64'(e.last));
        end
      end
      if (frame_done) begin
        n_fd++;
        check("frame_done_expected", 64'(exp_crc_q.size() != 0), 64'd1);
        if (exp_crc_q.size() != 0) check("crc_err", 64'(crc_err), 64'(exp_crc_q.pop_front()));
      end
      if (overrun) n_ovr++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge adc_clk);
    #1;
  endtask

  task automatic load_frame(input vec_t v);
    logic [NBITS-1:0] sx;
    logic [7:0]       c;
    c  = crc8_of(v.samples);
    sx = v.samples;
    if (v.corrupt) sx[40] = ~sx[40];
    tx = {sx, c};
    for (int k = 0; k < CH_NUM; k++)
      exp_q.push_back('{ch: 2'(k), data: sx[NBITS-1-k*SAMPLE_W -: SAMPLE_W],
                         last: (k == CH_NUM - 1) && !CRC_ON});
    exp_crc_q.push_back(v.exp_crc_err);
  endtask

  task automatic pulse_drdy();
    @(posedge adc_clk); #1 drdy = 1'b1;
    @(posedge adc_clk); #1 drdy = 1'b0;
  endtask

  task automatic wait_cs(input logic v, input int maxc, input string name, output int len);
    len = 0;
    while (cs_n !== v && len < maxc) begin
      @(posedge adc_clk); #1;
      len++;
    end
    check(name, 64'(cs_n), 64'(v));
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 50) begin
      @(posedge adc_clk); #1;
      c++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int len, fd0;
    fd0 = n_fd;
    load_frame(v);
    pulse_drdy();
    wait_cs(1'b0, 10, {name, "_cs_fall"}, len);
    wait_cs(1'b1, CS_LOW + 20, {name, "_cs_rise"}, len);
    check({name, "_cs_low_len"}, 64'(len), 64'(CS_LOW));
    wait_idle({name, "_idle"});
    check({name, "_frame_done_cnt"}, 64'(n_fd - fd0), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({sclk, din, cs_n, start, busy, smp_valid, smp_ch, smp_data, frame_done, overrun, crc_err});
  endfunction

  localparam logic [63:0] RST_VEC = 64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, 1'b0, 1'b0});

  initial begin
    int len, s0, r0, o0, c;
    logic low_seen;

    vecs[0] = '{samples: {24'h7FFFFF, 24'h800000, 24'h000001, 24'hABCDEF}, corrupt: 1'b0, exp_crc_err: 1'b0};
    vecs[1] = '{samples: {24'h000000, 24'hFFFFFF, 24'h123456, 24'h5A5A5A}, corrupt: 1'b0, exp_crc_err: 1'b0};
    vecs[2] = '{samples: {24'hA5A5A5, 24'h000080, 24'h800001, 24'hFEDCBA}, corrupt: 1'b0, exp_crc_err: 1'b0};
    vecs[3] = '{samples: {24'h0F0F0F, 24'h135790, 24'h2468AC, 24'hFFFFFE}, corrupt: 1'b1, exp_crc_err: CRC_ON};

    nRST = 1'b0; drdy = 1'b0; dout = 1'b0; start_req = 1'b0; stop_req = 1'b0;
    wreg_req = 1'b0; wreg_word = '0;
    cycles(3);
    check("reset_outputs", out_vec(), RST_VEC);
    nRST = 1'b1;
    cycles(2);

    // DRDY outside work mode must be ignored.
    s0 = n_smp;
    pulse_drdy();
    low_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (cs_n !== 1'b1) low_seen = 1'b1;
    end
    check("no_work_cs_low", 64'(low_seen), 64'd0);
    check("no_work_smp", 64'(n_smp - s0), 64'd0);

    @(posedge adc_clk); #1 start_req = 1'b1;
    @(posedge adc_clk); #1 start_req = 1'b0;
    check("start_level", 64'(start), 64'd1);

    for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Register write requested mid-frame is served once the frame completes.
    load_frame(vecs[0]);
    pulse_drdy();
    cycles(50);
    wreg_word = 16'hA55A;
    @(posedge adc_clk); #1 wreg_req = 1'b1;
    @(posedge adc_clk); #1 wreg_req = 1'b0; wreg_word = 16'h0000;
    wait_cs(1'b1, CS_LOW + 20, "wr_frame_end", len);
    wait_cs(1'b0, 20, "wr_cs_fall", len);
    r0 = n_rise;
    wait_cs(1'b1, WR_LOW + 20, "wr_cs_rise", len);
    check("wr_cs_low_len", 64'(len), 64'(WR_LOW));
    check("wr_din_word", 64'(rx_din), 64'hA55A);
    check("wr_bit_count", 64'(n_rise - r0), 64'(WREG_W));
    check("wr_din_idle", 64'(din), 64'd0);
    wait_idle("wr_idle");
    check("wr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Second DRDY edge mid-frame.
    o0 = n_ovr;
    load_frame(vecs[1]);
    pulse_drdy();
    wait_cs(1'b0, 10, "ovr_cs_fall", len);
    cycles(100);
    pulse_drdy();
    wait_cs(1'b1, CS_LOW + 20, "ovr_cs_rise", len);
    check("ovr_pulses", 64'(n_ovr - o0), 64'd1);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      if (cs_n !== 1'b1) low_seen = 1'b1;
    end
    check("ovr_no_second_frame", 64'(low_seen), 64'd0);
    check("ovr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset at bit 30, then a clean frame.
    load_frame(vecs[2]);
    pulse_drdy();
    wait_cs(1'b0, 10, "rst_cs_fall", len);
    r0 = n_rise;
    c = 0;
    while ((n_rise - r0) < 30 && c < CS_LOW) begin
      cycles(1);
      c++;
    end
    check("rst_reached_bit30", 64'(n_rise - r0), 64'd30);
    nRST = 1'b0;
    #1;
    check("midframe_reset_outputs", out_vec(), RST_VEC);
    exp_q.delete();
    exp_crc_q.delete();
    cycles(3);
    nRST = 1'b1;
    cycles(2);
    @(posedge adc_clk); #1 start_req = 1'b1;
    @(posedge adc_clk); #1 start_req = 1'b0;
    s0 = n_smp;
    run_frame(vecs[0], "post_rst");
    check("post_rst_smp_cnt", 64'(n_smp - s0), 64'(CH_NUM));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
